// File: rtl/right_shift_pipe.sv
// right_shift_pipe: two-stage pipelined 32-bit right shifter (SRL/SRA) with valid/ready handshakes.
// Define RIGHT_SHIFT_ROTATE_EN to add the rotate port and rotate-right operation.
module right_shift_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] idata,
    input  logic [4:0]  shift_len,
    input  logic        arith,
`ifdef RIGHT_SHIFT_ROTATE_EN
    input  logic        rotate,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] odata
);

    logic        s1_valid;
    logic [31:0] s1_data;
    logic [2:0]  s1_res;
    logic        s1_fill;
    logic        s1_rot;
    logic        s2_ready;
    logic        rot_in;
    logic        fill_in;
    logic [31:0] st16, st8;
    logic [31:0] st4, st2, st1;

`ifdef RIGHT_SHIFT_ROTATE_EN
    assign rot_in = rotate;
`else
    assign rot_in = 1'b0;
`endif

    // Fill comes from the original operand's sign bit; it is irrelevant while rotating.
    assign fill_in  = arith & idata[31] & ~rot_in;
    assign s2_ready = ~out_valid | out_ready;
    assign in_ready = (~s1_valid | s2_ready) & ~rst;

    always_comb begin
        st16 = idata;
        if (shift_len[4])
            st16 = rot_in ? {idata[15:0], idata[31:16]} : {{16{fill_in}}, idata[31:16]};
        st8 = st16;
        if (shift_len[3])
            st8 = rot_in ? {st16[7:0], st16[31:8]} : {{8{fill_in}}, st16[31:8]};
    end

    always_comb begin
        st4 = s1_data;
        if (s1_res[2])
            st4 = s1_rot ? {s1_data[3:0], s1_data[31:4]} : {{4{s1_fill}}, s1_data[31:4]};
        st2 = st4;
        if (s1_res[1])
            st2 = s1_rot ? {st4[1:0], st4[31:2]} : {{2{s1_fill}}, st4[31:2]};
        st1 = st2;
        if (s1_res[0])
            st1 = s1_rot ? {st2[0], st2[31:1]} : {s1_fill, st2[31:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= 32'h0;
            s1_res   <= 3'h0;
            s1_fill  <= 1'b0;
            s1_rot   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= st8;
                s1_res  <= shift_len[2:0];
                s1_fill <= fill_in;
                s1_rot  <= rot_in;
            end
        end
    end

    // Output register only captures real operands, so bubbles never disturb held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            odata     <= 32'h0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid)
                odata <= st1;
        end
    end

endmodule
